// File: rtl/psum_accumulator_if.sv
// Handshake bundle between the PE array, the psum accumulator and the writeback stage.
// The master drives psum lanes and consumer ready. The slave, the accumulator, drives the result head.
interface psum_accumulator_if #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4,
  parameter int ACC_WIDTH  = 20
);
  logic [BIT_WIDTH*NUM_KERNEL-1:0] psum;
  logic [NUM_KERNEL-1:0]           psum_val;
  logic [ACC_WIDTH*NUM_KERNEL-1:0] acc;
  logic                            acc_val;
  logic                            acc_rdy;

  modport master (output psum, psum_val, acc_rdy, input acc, acc_val);
  modport slave  (input psum, psum_val, acc_rdy, output acc, acc_val);
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates per-kernel psum lanes over a programmable number of beats.
// Completed result vectors queue in a small first-word-fall-through FIFO for the writeback stage.
module psum_accumulator #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4,
  parameter int ACC_WIDTH  = 20,
  parameter int FIFO_DEPTH = 4,
  parameter int REG_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  psum_accumulator_if.slave    bus,
  input  logic [7:0]           cfg_taps,
  output logic                 busy,
  output logic [REG_WIDTH-1:0] err_psum_val
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  state_t                                state;
  state_t                                state_next;
  logic                                  beat;
  logic                                  partial;
  logic                                  complete;
  logic [7:0]                            eff_taps;
  logic [7:0]                            taps_q;
  logic [7:0]                            tap_cnt;
  logic [NUM_KERNEL-1:0][ACC_WIDTH-1:0]  acc_q;
  logic [NUM_KERNEL-1:0][ACC_WIDTH-1:0]  lane_sum;
  logic [ACC_WIDTH*NUM_KERNEL-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                      wr_ptr;
  logic [PTR_W-1:0]                      rd_ptr;
  logic [CNT_W-1:0]                      count;
  logic                                  fifo_full;
  logic                                  almost_full;
  logic                                  push;
  logic                                  pop;
  logic [2:0]                            err_q;

  assign beat     = &bus.psum_val;
  assign partial  = (|bus.psum_val) && !beat;
  assign eff_taps = (cfg_taps == 8'd0) ? 8'd1 : cfg_taps;

  // Each lane is sign-extended to the accumulator width and wraps modulo 2^ACC_WIDTH.
  always_comb begin
    for (int k = 0; k < NUM_KERNEL; k++) begin
      lane_sum[k] = acc_q[k] + {{(ACC_WIDTH-BIT_WIDTH){bus.psum[BIT_WIDTH*k+BIT_WIDTH-1]}},
                                bus.psum[BIT_WIDTH*k +: BIT_WIDTH]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (beat && eff_taps != 8'd1) state_next = ACCUM;
      ACCUM:   if (complete)                 state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A group of one tap completes on the very beat that opens it, using the freshly sampled tap count.
  always_comb begin
    busy     = 1'b0;
    complete = 1'b0;
    case (state)
      IDLE:    complete = beat && (eff_taps == 8'd1);
      ACCUM: begin
        busy     = 1'b1;
        complete = beat && (tap_cnt == taps_q - 8'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      tap_cnt <= '0;
      taps_q  <= 8'd1;
    end else if (beat) begin
      if (state == IDLE) taps_q <= eff_taps;
      if (complete) begin
        acc_q   <= '0;
        tap_cnt <= '0;
      end else begin
        acc_q   <= lane_sum;
        tap_cnt <= tap_cnt + 8'd1;
      end
    end
  end

  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  assign almost_full = (count == CNT_W'(FIFO_DEPTH - 1));
  assign pop         = bus.acc_val && bus.acc_rdy;
  assign push        = complete && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= lane_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Bit 0 flags a partial lane valid. Bit 1 flags a dropped result. Bit 2 warns of an almost-full push.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      if (partial)                            err_q[0] <= 1'b1;
      if (complete && fifo_full && !pop)      err_q[1] <= 1'b1;
      if (complete && almost_full)            err_q[2] <= 1'b1;
    end
  end

  assign bus.acc_val  = (count != '0);
  assign bus.acc      = bus.acc_val ? mem[rd_ptr] : '0;
  assign err_psum_val = REG_WIDTH'(err_q);

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed and randomized checks of psum_accumulator.
// The bench compares the DUT against a queue-based reference model of the result stream.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_taps;
  logic        busy;
  logic [31:0] err_psum_val;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: running integer lane sums, a beat count and a queue of expected FIFO contents.
  logic [79:0] exp_q[$];
  int          m_sum[4];
  int          m_cnt;
  int          m_taps;
  logic [2:0]  m_err;

  psum_accumulator_if #(.BIT_WIDTH(8), .NUM_KERNEL(4), .ACC_WIDTH(20)) bus ();

  psum_accumulator #(
    .BIT_WIDTH(8), .NUM_KERNEL(4), .ACC_WIDTH(20), .FIFO_DEPTH(4), .REG_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cfg_taps(cfg_taps),
    .busy(busy),
    .err_psum_val(err_psum_val)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk8(int a, int b, int c, int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [79:0] pk20(int a, int b, int c, int d);
    return {d[19:0], c[19:0], b[19:0], a[19:0]};
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    for (int k = 0; k < 4; k++) m_sum[k] = 0;
    m_cnt = 0;
    m_taps = 1;
    m_err = '0;
  endtask

  task automatic modelStep(input logic [31:0] lanes, input logic [3:0] val,
                           input logic [7:0] taps, input logic rdy);
    bit          do_pop;
    bit          was_full;
    logic [79:0] res;
    do_pop   = rdy && (exp_q.size() > 0);
    was_full = (exp_q.size() == 4);
    if (val != 4'h0 && val != 4'hF) m_err[0] = 1'b1;
    if (val == 4'hF) begin
      if (m_cnt == 0) m_taps = (taps == 8'd0) ? 1 : int'(taps);
      for (int k = 0; k < 4; k++) m_sum[k] += int'($signed(lanes[8*k +: 8]));
      m_cnt++;
      if (m_cnt == m_taps) begin
        res = pk20(m_sum[0], m_sum[1], m_sum[2], m_sum[3]);
        if (exp_q.size() == 3) m_err[2] = 1'b1;
        if (do_pop) void'(exp_q.pop_front());
        if (!was_full || do_pop) exp_q.push_back(res);
        else                     m_err[1] = 1'b1;
        for (int k = 0; k < 4; k++) m_sum[k] = 0;
        m_cnt = 0;
        do_pop = 1'b0;
      end
    end
    if (do_pop) void'(exp_q.pop_front());
  endtask

  task automatic checkOutput();
    check("acc_val", 80'(bus.acc_val), 80'(exp_q.size() > 0));
    check("acc",     bus.acc,          (exp_q.size() > 0) ? exp_q[0] : 80'd0);
    check("busy",    80'(busy),        80'(m_cnt > 0));
    check("err",     80'(err_psum_val), 80'(m_err));
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model, then compare.
  task automatic applyStimulus(input logic r, input logic [31:0] lanes, input logic [3:0] val,
                               input logic [7:0] taps, input logic rdy);
    rst          = r;
    bus.psum     = lanes;
    bus.psum_val = val;
    cfg_taps     = taps;
    bus.acc_rdy  = rdy;
    @(posedge clk);
    if (r) modelReset();
    else   modelStep(lanes, val, taps, rdy);
    #1;
    checkOutput();
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 32'd0, 4'h0, 8'd1, rdy);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 32'd0, 4'h0, 8'd1, 1'b1);
  endtask

  initial begin
    rst = 1'b1; bus.psum = '0; bus.psum_val = '0; cfg_taps = 8'd1; bus.acc_rdy = 1'b0;
    modelReset();

    doReset();
    check("reset_acc",  bus.acc, 80'd0);
    check("reset_err",  80'(err_psum_val), 80'd0);

    // taps=3 accumulation of three beats
    applyStimulus(1'b0, pk8(1, 2, 3, 4), 4'hF, 8'd3, 1'b1);
    applyStimulus(1'b0, pk8(5, 6, 7, 8), 4'hF, 8'd3, 1'b1);
    check("tp1_no_early_val", 80'(bus.acc_val), 80'd0);
    applyStimulus(1'b0, pk8(-1, -1, -1, -1), 4'hF, 8'd3, 1'b1);
    check("tp1_result", bus.acc, pk20(5, 7, 9, 11));
    idle(1'b1);
    check("tp1_single_pulse", 80'(bus.acc_val), 80'd0);

    // taps=0 behaves as taps=1: every beat is a result, never busy
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, pk8(127, -128, 0, -1), 4'hF, 8'd0, 1'b1);
      check("tp2_result", bus.acc, {20'hFFFFF, 20'h00000, 20'hFFF80, 20'h0007F});
      check("tp2_busy", 80'(busy), 80'd0);
    end
    idle(1'b1);

    // Consumer stalled: fill, overflow, then drain
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, pk8(i + 1, i + 2, i + 3, i + 4), 4'hF, 8'd1, 1'b0);
    check("tp3_head_stable", bus.acc, pk20(1, 2, 3, 4));
    check("tp3_err", 80'(err_psum_val), 80'h6);
    for (int i = 0; i < 5; i++) idle(1'b1);
    check("tp3_drained", 80'(bus.acc_val), 80'd0);

    // Partial valid between two beats is ignored
    doReset();
    applyStimulus(1'b0, pk8(10, 20, 30, 40), 4'hF, 8'd2, 1'b1);
    applyStimulus(1'b0, pk8(99, 99, 99, 99), 4'b0101, 8'd2, 1'b1);
    applyStimulus(1'b0, pk8(1, -2, 3, -4), 4'hF, 8'd2, 1'b1);
    check("tp4_result", bus.acc, pk20(11, 18, 33, 36));
    check("tp4_err", 80'(err_psum_val), 80'h1);

    // Reset mid-group discards partial sums
    doReset();
    applyStimulus(1'b0, pk8(50, 50, 50, 50), 4'hF, 8'd4, 1'b1);
    applyStimulus(1'b0, pk8(50, 50, 50, 50), 4'hF, 8'd4, 1'b1);
    doReset();
    check("tp5_busy_cleared", 80'(busy), 80'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, pk8(1, 1, 1, 1), 4'hF, 8'd4, 1'b1);
    check("tp5_result", bus.acc, pk20(4, 4, 4, 4));

    // Maximum tap count with maximum positive lanes
    doReset();
    for (int i = 0; i < 254; i++) applyStimulus(1'b0, pk8(127, 127, 127, 127), 4'hF, 8'd255, 1'b1);
    check("tp6_not_yet", 80'(bus.acc_val), 80'd0);
    applyStimulus(1'b0, pk8(127, 127, 127, 127), 4'hF, 8'd255, 1'b1);
    check("tp6_result", bus.acc, {4{20'h07E81}});
    idle(1'b1);

    // Randomized traffic: slow consumer first, then a mostly-ready one
    doReset();
    for (int i = 0; i < 1200; i++) begin
      logic [3:0] v;
      int         r;
      r = $urandom_range(0, 99);
      if (r < 80)      v = 4'hF;
      else if (r < 90) v = 4'($urandom);
      else             v = 4'h0;
      if ($urandom_range(0, 149) == 0) doReset();
      else applyStimulus(1'b0, $urandom, v, 8'($urandom_range(0, 4)),
                         (i < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
